// File: rtl/armstrong_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : armstrong_scan_ctrl_if
// Description : Chip-select / write / read data bus between the Armstrong
//               scan sequencer (master) and the Armstrong-check peripheral
//               (slave).
//               oChip_select_n - chip select, active low       (master -> slave)
//               oWrite_n       - write enable, active low      (master -> slave)
//               oRead_n        - read enable, active low       (master -> slave)
//               oData[15:0]    - write data {6'b0, number}     (master -> slave)
//               iData[15:0]    - read data, bit0 = verdict     (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface armstrong_scan_ctrl_if;
  logic        oChip_select_n;
  logic        oWrite_n;
  logic        oRead_n;
  logic [15:0] oData;
  logic [15:0] iData;

  modport master (
    output oChip_select_n,
    output oWrite_n,
    output oRead_n,
    output oData,
    input  iData
  );

  modport slave (
    input  oChip_select_n,
    input  oWrite_n,
    input  oRead_n,
    input  oData,
    output iData
  );
endinterface
`default_nettype wire

// File: rtl/armstrong_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : armstrong_scan_ctrl
// Description : Bus-master sequencer for the Armstrong-number check
//               peripheral. Sweeps [start_num, end_num]; for every value it
//               writes the number, waits out the peripheral's compute
//               pipeline, reads the verdict and reports each hit.
// Ports       : clk, reset (async, active-high)
//               start / start_num / end_num  - host sweep request
//               busy / done                  - sweep status, done is a pulse
//               hit_count / hit_valid / hit_num - hit reporting
//               bus (armstrong_scan_ctrl_if.master) - peripheral bus
//               fifo_pop / fifo_data / fifo_empty / fifo_overflow
//                                            - optional hit FIFO
// Options     : define ARMSTRONG_SCAN_FIFO_EN to build the FIFO_DEPTH-entry
//               hit FIFO; otherwise the FIFO outputs are tied off.
// Revision    : 1.0 - initial release
// ============================================================================
module armstrong_scan_ctrl #(
  parameter int unsigned COMPUTE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         start,
  input  wire logic [9:0]                   start_num,
  input  wire logic [9:0]                   end_num,
  output logic                              busy,
  output logic                              done,
  output logic [10:0]                       hit_count,
  output logic                              hit_valid,
  output logic [9:0]                        hit_num,
  armstrong_scan_ctrl_if.master             bus,
  input  wire logic                         fifo_pop,
  output logic [9:0]                        fifo_data,
  output logic                              fifo_empty,
  output logic                              fifo_overflow
);

  // Counter just wide enough to hold COMPUTE_CYCLES-1.
  localparam int unsigned CNT_W = (COMPUTE_CYCLES > 2) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_READ    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       cur_num_q, cur_num_d;
  logic [9:0]       end_num_q, end_num_d;
  logic [10:0]      hit_count_q, hit_count_d;
  logic [9:0]       hit_num_q, hit_num_d;
  logic             hit_valid_q, hit_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             rd_n_q, rd_n_d;
  logic [15:0]      odata_q, odata_d;

  logic             start_accept;  // start taken in IDLE (either range order)
  logic             hit_push;      // verdict sampled as a hit this cycle

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_num_d    = cur_num_q;
    end_num_d    = end_num_q;
    hit_count_d  = hit_count_q;
    hit_num_d    = hit_num_q;
    hit_valid_d  = 1'b0;
    start_accept = 1'b0;
    hit_push     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          hit_count_d  = '0;
          if (start_num <= end_num) begin
            cur_num_d = start_num;
            end_num_d = end_num;
            state_d   = ST_WRITE;
          end else begin
            // Empty range: report completion without touching the bus.
            state_d = ST_FINISH;
          end
        end
      end
      ST_WRITE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cnt_q == '0) begin
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus.iData[0]) begin
          hit_valid_d = 1'b1;
          hit_num_d   = cur_num_q;
          hit_count_d = hit_count_q + 11'd1;
          hit_push    = 1'b1;
        end
        // Equality test (not an increment-and-compare) so end_num=1023
        // terminates without cur_num ever wrapping to 0.
        if (cur_num_q == end_num_q) begin
          state_d = ST_FINISH;
        end else begin
          cur_num_d = cur_num_q + 10'd1;
          state_d   = ST_WRITE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so each strobe is
  // valid during exactly the cycle its state is held.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FINISH);
    cs_n_d  = !((state_d == ST_WRITE) || (state_d == ST_COMPUTE));
    wr_n_d  = (state_d != ST_WRITE);
    rd_n_d  = (state_d != ST_READ);
    odata_d = odata_q;
    if (state_d == ST_WRITE) begin
      odata_d = {6'b0, cur_num_d};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_num_q   <= '0;
      end_num_q   <= '0;
      hit_count_q <= '0;
      hit_num_q   <= '0;
      hit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      odata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_num_q   <= cur_num_d;
      end_num_q   <= end_num_d;
      hit_count_q <= hit_count_d;
      hit_num_q   <= hit_num_d;
      hit_valid_q <= hit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      odata_q     <= odata_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign hit_count          = hit_count_q;
  assign hit_valid          = hit_valid_q;
  assign hit_num            = hit_num_q;
  assign bus.oChip_select_n = cs_n_q;
  assign bus.oWrite_n       = wr_n_q;
  assign bus.oRead_n        = rd_n_q;
  assign bus.oData          = odata_q;

  // Only the verdict bit of the read data carries meaning.
  logic unused_idata;
  assign unused_idata = ^bus.iData[15:1];

  // --------------------------------------------------------------------------
  // Hit FIFO
  // --------------------------------------------------------------------------
`ifdef ARMSTRONG_SCAN_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        f_empty;
  logic        f_full;
  logic        do_pop;
  logic        do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign f_empty = (wr_ptr_q == rd_ptr_q);
  assign f_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    do_pop     = fifo_pop && !f_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    do_push    = hit_push && (!f_full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (start_accept) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (hit_push && !do_push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cur_num_q;
    end
  end

  assign fifo_data     = f_empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_empty    = f_empty;
  assign fifo_overflow = overflow_q;
`else
  assign fifo_data     = '0;
  assign fifo_empty    = 1'b1;
  assign fifo_overflow = 1'b0;

  logic unused_fifo;
  assign unused_fifo = ^{fifo_pop, hit_push, start_accept, 32'(FIFO_DEPTH)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_armstrong_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_armstrong_scan_ctrl
// Description : Directed self-checking bench for armstrong_scan_ctrl with a
//               behavioural Armstrong-check peripheral on the bus.
//               Define ARMSTRONG_SCAN_FIFO_EN to exercise the hit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armstrong_scan_ctrl;

  localparam int COMPUTE_CYCLES = 4;
  localparam int FIFO_DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  start_num = '0;
  logic [9:0]  end_num = '0;
  logic        busy;
  logic        done;
  logic [10:0] hit_count;
  logic        hit_valid;
  logic [9:0]  hit_num;
  logic        fifo_pop = 1'b0;
  logic [9:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_overflow;

  armstrong_scan_ctrl_if bus ();

  armstrong_scan_ctrl #(
    .COMPUTE_CYCLES (COMPUTE_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_num     (start_num),
    .end_num       (end_num),
    .busy          (busy),
    .done          (done),
    .hit_count     (hit_count),
    .hit_valid     (hit_valid),
    .hit_num       (hit_num),
    .bus           (bus),
    .fifo_pop      (fifo_pop),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sum of the cubes of the decimal digits equals the number.
  function automatic logic is_arm(input int n);
    int s = 0;
    int v = n;
    do begin
      s += (v % 10) * (v % 10) * (v % 10);
      v = v / 10;
    end while (v != 0);
    return (s == n);
  endfunction

  // ---------------------------------------------------------------- monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   hits[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   first_wr_cyc = -1;
  int   wr_cnt = 0;
  int   last_wr = -1;
  int   comp_cnt = 0;
  logic strobe_seen = 1'b0;
  int   per_num = 0;

  initial bus.iData = 16'h0;

  // Peripheral model and observers, all sampled mid-cycle.
  always @(negedge clk) begin
    if (hit_valid) hits.push_back(int'(hit_num));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!bus.oChip_select_n || !bus.oWrite_n || !bus.oRead_n) strobe_seen = 1'b1;
    if (!bus.oChip_select_n && !bus.oWrite_n) begin
      per_num  = int'(bus.oData[9:0]);
      last_wr  = per_num;
      wr_cnt++;
      comp_cnt = 0;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end else if (!bus.oChip_select_n) begin
      comp_cnt++;
    end
    if (!bus.oRead_n) begin
      check_val("compute_len", comp_cnt, COMPUTE_CYCLES);
      bus.iData = {15'h2AB5, is_arm(per_num)};
    end
  end

  // ------------------------------------------------------------------ tasks
  int done_base = 0;

  task automatic start_sweep(input int s, input int e);
    @(posedge clk);
    hits.delete();
    done_base    = done_cnt;
    first_wr_cyc = -1;
    wr_cnt       = 0;
    strobe_seen  = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    start_num = 10'(s);
    end_num   = 10'(e);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val(tag, (done_cnt != done_base), 1);
    @(negedge clk);
  endtask

  function automatic int hit_at(input int i);
    return (hits.size() > i) ? hits[i] : -1;
  endfunction

  // --------------------------------------------------------------- stimulus
  int exp_hits[6] = '{0, 1, 153, 370, 371, 407};

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_hit_count", hit_count, 0);
    check_val("rst_hit_valid", hit_valid, 0);
    check_val("rst_hit_num", hit_num, 0);
    check_val("rst_cs_n", bus.oChip_select_n, 1);
    check_val("rst_wr_n", bus.oWrite_n, 1);
    check_val("rst_rd_n", bus.oRead_n, 1);
    check_val("rst_odata", bus.oData, 0);
    check_val("rst_fifo_empty", fifo_empty, 1);
    check_val("rst_fifo_ovf", fifo_overflow, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 150..160, single hit at 153, 11 numbers x 7 cycles
    start_sweep(150, 160);
    wait_done("t1_done", 200);
    check_val("t1_hits", hits.size(), 1);
    check_val("t1_hit0", hit_at(0), 153);
    check_val("t1_hit_count", hit_count, 1);
    check_val("t1_latency", done_cyc - first_wr_cyc, 77);
    check_val("t1_writes", wr_cnt, 11);
    check_val("t1_busy_end", busy, 0);

    // 2: full range, no wrap past 1023
    start_sweep(0, 1023);
    wait_done("t2_done", 1024 * 7 + 100);
    repeat (20) @(negedge clk);
    check_val("t2_hits", hits.size(), 6);
    for (int i = 0; i < 6; i++) check_val("t2_hit", hit_at(i), exp_hits[i]);
    check_val("t2_hit_count", hit_count, 6);
    check_val("t2_writes", wr_cnt, 1024);
    check_val("t2_last_write", last_wr, 1023);
    check_val("t2_single_done", done_cnt - done_base, 1);
    check_val("t2_busy_end", busy, 0);

`ifdef ARMSTRONG_SCAN_FIFO_EN
    // 6: depth-4 FIFO keeps the first four hits and flags the dropped ones
    check_val("t6_not_empty", fifo_empty, 0);
    check_val("t6_overflow", fifo_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_val("t6_fifo_data", fifo_data, exp_hits[i]);
      fifo_pop = 1'b1;
      @(negedge clk);
      fifo_pop = 1'b0;
    end
    check_val("t6_empty", fifo_empty, 1);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    check_val("t6_pop_empty", fifo_empty, 1);
    check_val("t6_ovf_sticky", fifo_overflow, 1);
`else
    check_val("nofifo_empty", fifo_empty, 1);
    check_val("nofifo_data", fifo_data, 0);
    check_val("nofifo_ovf", fifo_overflow, 0);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    check_val("nofifo_pop", fifo_empty, 1);
`endif

    // 3: reversed range finishes at once with no bus traffic
    start_sweep(20, 10);
    wait_done("t3_done", 20);
    repeat (5) @(negedge clk);
    check_val("t3_hit_count", hit_count, 0);
    check_val("t3_no_strobe", strobe_seen, 0);
    check_val("t3_busy_end", busy, 0);
    check_val("t3_ovf_clear", fifo_overflow, 0);
    check_val("t3_fifo_empty", fifo_empty, 1);

    // 4: start while busy is ignored
    start_sweep(0, 400);
    repeat (500) @(negedge clk);
    start     = 1'b1;
    start_num = 10'd5;
    end_num   = 10'd6;
    @(negedge clk);
    start = 1'b0;
    check_val("t4_still_busy", busy, 1);
    wait_done("t4_done", 401 * 7 + 100);
    check_val("t4_hit_count", hit_count, 5);
    check_val("t4_hits", hits.size(), 5);
    check_val("t4_hit4", hit_at(4), 371);
    check_val("t4_last_write", last_wr, 400);
    check_val("t4_writes", wr_cnt, 401);
    check_val("t4_single_done", done_cnt - done_base, 1);

    // 5: asynchronous reset during COMPUTE aborts the sweep
    start_sweep(0, 500);
    repeat (300) @(negedge clk);
    begin
      int n = 0;
      while (!(bus.oChip_select_n == 1'b0 && bus.oWrite_n == 1'b1) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_val("t5_in_compute", (n < 20), 1);
    end
    check_val("t5_pre_count", hit_count, 2);
    #2 reset = 1'b1;
    #1;
    check_val("t5_cs_n", bus.oChip_select_n, 1);
    check_val("t5_wr_n", bus.oWrite_n, 1);
    check_val("t5_rd_n", bus.oRead_n, 1);
    check_val("t5_busy", busy, 0);
    check_val("t5_hit_count", hit_count, 0);
    done_base = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t5_no_done", done_cnt - done_base, 0);
    start_sweep(370, 371);
    wait_done("t5b_done", 100);
    check_val("t5b_hit_count", hit_count, 2);
    check_val("t5b_hit0", hit_at(0), 370);
    check_val("t5b_hit1", hit_at(1), 371);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
